// File: rtl/nunchuck_i2c_target.sv
// I2C target emulating an unencrypted Wii Nunchuck; serves a 6-byte report built from parallel inputs.
// Optional init-write gating of the report is enabled by defining NUNCHUCK_INIT_GATE_EN.
//
// state       | meaning
// S_IDLE      | bus ignored until START
// S_ADDR      | shifting address byte
// S_ADDR_ACK  | address matched, ACKing
// S_WR_DATA   | shifting a written byte
// S_WR_ACK    | ACKing a written byte
// S_RD_DATA   | driving report byte bits
// S_RD_ACK    | sampling master ACK/NACK
// S_WAIT_STOP | not addressed / done; wait for START or STOP
module nunchuck_i2c_target #(
    parameter logic [6:0] ADDR        = 7'h52,
    parameter int         SYNC_STAGES = 2,
    parameter int         HOLD_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic [9:0] accel_x,
    input  logic [9:0] accel_y,
    input  logic [9:0] accel_z,
    input  logic       c,
    input  logic       z,
    output logic       busy,
    output logic       rd_done
);

    localparam int HOLD_LD = (HOLD_CYC < 1) ? 1 : HOLD_CYC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   start_det, stop_det, scl_rise, scl_fall;
    logic [3:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [7:0]             rx_byte;
    logic [7:0]             ptr;
    logic [7:0]             tx_byte;
    logic [47:0]            snap;
    logic                   rw;
    logic                   first;
    logic [7:0]             hold_cnt;
    logic                   oe_pend;
    logic                   init_ok;

    // Synchronizers run freely through reset so edge detection is valid as soon as reset drops.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
        sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        scl_d    <= scl_s;
        sda_d    <= sda_s;
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign rx_byte   = {shreg, sda_s};

`ifdef NUNCHUCK_INIT_GATE_EN
    logic f0_ok, fb_ok;
    assign init_ok = f0_ok & fb_ok;
`else
    assign init_ok = 1'b1;
`endif

    always_comb begin
        tx_byte = 8'hFF;
        if (init_ok) begin
            case (ptr)
                8'd0:    tx_byte = snap[47:40];
                8'd1:    tx_byte = snap[39:32];
                8'd2:    tx_byte = snap[31:24];
                8'd3:    tx_byte = snap[23:16];
                8'd4:    tx_byte = snap[15:8];
                8'd5:    tx_byte = snap[7:0];
                default: tx_byte = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rd_done  <= 1'b0;
            ptr      <= 8'd0;
            snap     <= 48'd0;
            bit_cnt  <= 4'd0;
            shreg    <= 7'd0;
            rw       <= 1'b0;
            first    <= 1'b0;
            hold_cnt <= 8'd0;
            oe_pend  <= 1'b0;
`ifdef NUNCHUCK_INIT_GATE_EN
            f0_ok    <= 1'b0;
            fb_ok    <= 1'b0;
`endif
        end else begin
            rd_done <= 1'b0;
            // SDA only moves once the hold window after an SCL fall has expired.
            if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
                if (hold_cnt == 8'd1) sda_oe <= oe_pend;
            end

            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= 4'd0;
                busy     <= 1'b1;
                sda_oe   <= 1'b0;
                hold_cnt <= 8'd0;
                oe_pend  <= 1'b0;
            end else if (stop_det) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
                hold_cnt <= 8'd0;
                oe_pend  <= 1'b0;
            end else if (scl_fall) begin
                hold_cnt <= 8'(HOLD_LD);
                oe_pend  <= 1'b0;
                case (state)
                    S_ADDR_ACK, S_WR_ACK: oe_pend <= 1'b1;
                    S_RD_DATA: begin
                        if (bit_cnt == 4'd8) state <= S_RD_ACK;
                        else                 oe_pend <= ~tx_byte[3'd7 - bit_cnt[2:0]];
                    end
                    default: ;
                endcase
            end else if (scl_rise) begin
                case (state)
                    S_ADDR: begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (shreg == ADDR) begin
                                state <= S_ADDR_ACK;
                                rw    <= sda_s;
                            end else begin
                                state <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            snap  <= {stick_x, stick_y, accel_x[9:2], accel_y[9:2], accel_z[9:2],
                                      accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z};
                            state <= S_RD_DATA;
                        end else begin
                            first <= 1'b1;
                            state <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= S_WR_ACK;
                            if (first) begin
                                ptr   <= rx_byte;
                                first <= 1'b0;
                            end else begin
`ifdef NUNCHUCK_INIT_GATE_EN
                                if (ptr == 8'hF0 && rx_byte == 8'h55) f0_ok <= 1'b1;
                                if (ptr == 8'hFB && rx_byte == 8'h00 && f0_ok) fb_ok <= 1'b1;
`endif
                                ptr <= ptr + 8'd1;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        bit_cnt <= 4'd0;
                        state   <= S_WR_DATA;
                    end
                    S_RD_DATA: bit_cnt <= bit_cnt + 4'd1;
                    S_RD_ACK: begin
                        if (ptr == 8'd5) rd_done <= 1'b1;
                        if (!sda_s) begin
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= 4'd0;
                            state   <= S_RD_DATA;
                        end else begin
                            state <= S_WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nunchuck_i2c_target.sv
// Bench for nunchuck_i2c_target: bit-banged I2C master, reference model and scoreboard.
// Honours NUNCHUCK_INIT_GATE_EN in its model when the design is built with it.
module tb_nunchuck_i2c_target;

    localparam int         Q      = 5;
    localparam logic [6:0] T_ADDR = 7'h52;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic       sda_oe, busy, rd_done;
    logic [7:0] stick_x = 8'h00, stick_y = 8'h00;
    logic [9:0] accel_x = 10'h0, accel_y = 10'h0, accel_z = 10'h0;
    logic       c = 1'b0, z = 1'b0;
    wire        sda_bus = ~(m_low | sda_oe);

    always #5 clk = ~clk;

    nunchuck_i2c_target dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .stick_x (stick_x),
        .stick_y (stick_y),
        .accel_x (accel_x),
        .accel_y (accel_y),
        .accel_z (accel_z),
        .c       (c),
        .z       (z),
        .busy    (busy),
        .rd_done (rd_done)
    );

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    string      obs_tag;
    logic [7:0] obs_val;
    event       obs_ev;
    int         n_cmp = 0, n_bad = 0;
    int         rd_cnt = 0, exp_rd_done = 0;
    int         viol = 0;
    bit         no_drive = 1'b0;
    logic [7:0] fixed_exp [8];

    int m_ptr = 0;
    bit m_f0 = 1'b0, m_fb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(obs_ev);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_%s: got %0h, want nothing", obs_tag, obs_val);
            end else begin
                e = exp_q.pop_front();
                chk(e.tag, {24'd0, obs_val}, {24'd0, e.val});
            end
        end
    end

    always @(negedge clk) begin
        if (rd_done === 1'b1) rd_cnt++;
        if (no_drive && sda_oe === 1'b1) viol++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Reference report: plain arithmetic on the current inputs.
    function automatic logic [7:0] rep(input int i);
        case (i)
            0: return stick_x;
            1: return stick_y;
            2: return 8'(accel_x / 4);
            3: return 8'(accel_y / 4);
            4: return 8'(accel_z / 4);
            default: return 8'((accel_z % 4) * 64 + (accel_y % 4) * 16 + (accel_x % 4) * 4
                               + (c ? 0 : 2) + (z ? 0 : 1));
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int p);
        bit ok;
`ifdef NUNCHUCK_INIT_GATE_EN
        ok = m_f0 && m_fb;
`else
        ok = 1'b1;
`endif
        return (ok && p <= 5) ? rep(p) : 8'hFF;
    endfunction

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic i2c_start;
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b1; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b0; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        b = sda_bus;  tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic observe(input string tag, input logic [7:0] v);
        obs_tag = tag;
        obs_val = v;
        -> obs_ev;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        observe("ack", {7'd0, a});
    endtask

    task automatic recv_byte(input logic nack);
        logic [7:0] b = 8'h00;
        logic       v;
        for (int i = 0; i < 8; i++) begin
            recv_bit(v);
            b = {b[6:0], v};
        end
        observe("rd", b);
        send_bit(nack);
    endtask

    task automatic write_txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input bit do_stop);
        logic [7:0] d [3];
        d[0] = b0; d[1] = b1; d[2] = b2;
        push("addr_ack_w", 8'h00);
        for (int i = 0; i < n; i++) push("wr_ack", 8'h00);
        m_ptr = d[0];
        for (int i = 1; i < n; i++) begin
            if (m_ptr == 8'hF0 && d[i] == 8'h55) m_f0 = 1'b1;
            if (m_ptr == 8'hFB && d[i] == 8'h00 && m_f0) m_fb = 1'b1;
            m_ptr = (m_ptr + 1) % 256;
        end
        i2c_start;
        send_byte({T_ADDR, 1'b0});
        for (int i = 0; i < n; i++) send_byte(d[i]);
        if (do_stop) i2c_stop;
    endtask

    task automatic read_txn(input int n, input bit use_model, input int chg_at,
                            input logic [7:0] chg_val);
        int p = m_ptr;
        push("addr_ack_r", 8'h00);
        for (int i = 0; i < n; i++) begin
            if (use_model) push("rd_byte", exp_byte(p));
            else           push("rd_fixed", fixed_exp[i]);
            if (p == 5) exp_rd_done++;
            if (i < n - 1) p = (p + 1) % 256;
        end
        m_ptr = p;
        i2c_start;
        send_byte({T_ADDR, 1'b1});
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1);
            if (i == chg_at) stick_x = chg_val;
        end
        i2c_stop;
        tick(4);
        chk("rd_done_count", rd_cnt, exp_rd_done);
    endtask

    task automatic do_init;
        write_txn(2, 8'hF0, 8'h55, 8'h00, 1'b1);
        write_txn(2, 8'hFB, 8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        int k;
        tick(5);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_done", rd_done, 0);
        rst = 1'b0;
        tick(10);

        stick_x = 8'h80; stick_y = 8'h7F;
        accel_x = 10'h2AD; accel_y = 10'h155; accel_z = 10'h3FF;
        c = 1'b1; z = 1'b0;

        // Init gate: read before init, FB before F0, then proper sequence.
        read_txn(2, 1'b1, -1, 8'h00);
        write_txn(2, 8'hFB, 8'h00, 8'h00, 1'b1);
        write_txn(1, 8'h00, 8'h00, 8'h00, 1'b1);
        read_txn(6, 1'b1, -1, 8'h00);
        do_init;

        // Address mismatch: target must never drive SDA.
        no_drive = 1'b1;
        push("nack_bad_addr", 8'h01);
        i2c_start;
        chk("busy_after_start", busy, 1);
        send_byte(8'hA6);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom));
        i2c_stop;
        no_drive = 1'b0;
        chk("no_drive_bad_addr", viol, 0);
        chk("busy_after_stop", busy, 0);

        // Pointer then read against literal expected bytes.
        fixed_exp[0] = 8'h80; fixed_exp[1] = 8'h7F; fixed_exp[2] = 8'hAB;
        fixed_exp[3] = 8'h55; fixed_exp[4] = 8'hFF; fixed_exp[5] = 8'hD5;
        write_txn(1, 8'h00, 8'h00, 8'h00, 1'b1);
        read_txn(6, 1'b0, -1, 8'h00);

        // Snapshot stability.
        write_txn(1, 8'h00, 8'h00, 8'h00, 1'b1);
        read_txn(6, 1'b1, 0, 8'h10);
        write_txn(1, 8'h00, 8'h00, 8'h00, 1'b1);
        read_txn(1, 1'b1, -1, 8'h00);
        stick_x = 8'h80;

        // Overrun past the report and pointer wrap.
        write_txn(1, 8'h00, 8'h00, 8'h00, 1'b1);
        read_txn(8, 1'b1, -1, 8'h00);
        write_txn(1, 8'hFE, 8'h00, 8'h00, 1'b1);
        read_txn(4, 1'b1, -1, 8'h00);

        // Repeated START mid-write.
        write_txn(1, 8'h02, 8'h00, 8'h00, 1'b0);
        read_txn(4, 1'b1, -1, 8'h00);

        // Reset while the target drives the address ACK.
        i2c_start;
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : T_ADDR[i-1]);
        m_low = 1'b0;
        k = 0;
        while (sda_oe !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        chk("ack_driven_before_rst", sda_oe, 1);
        rst = 1'b1;
        tick(1);
        chk("oe_after_rst", sda_oe, 0);
        chk("busy_after_rst", busy, 0);
        rst = 1'b0;
        m_ptr = 0; m_f0 = 1'b0; m_fb = 1'b0;
        no_drive = 1'b1;
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
        for (int i = 0; i < 9; i++) send_bit(1'($urandom));
        chk("busy_ignored_bus", busy, 0);
        i2c_stop;
        no_drive = 1'b0;
        chk("no_drive_after_rst", viol, 0);
        read_txn(3, 1'b1, -1, 8'h00);
        do_init;

        // Randomized traffic.
        for (int r = 0; r < 12; r++) begin
            stick_x = 8'($urandom); stick_y = 8'($urandom);
            accel_x = 10'($urandom); accel_y = 10'($urandom); accel_z = 10'($urandom);
            c = 1'($urandom); z = 1'($urandom);
            if ($urandom_range(0, 3) != 0)
                write_txn($urandom_range(1, 3), 8'($urandom_range(0, 7)), 8'($urandom),
                          8'($urandom), 1'b1);
            read_txn($urandom_range(1, 8), 1'b1, -1, 8'h00);
        end

        tick(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
